cpm5n_dma5_fifo_wr_arb: RTL



---
 rtl/cpm5n_dma5_fifo_wr_arb.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cpm5n_dma5_fifo_wr_arb.sv
// cpm5n_dma5_fifo_wr_arb
//
// Packet-atomic round-robin write arbiter. It shares the single write port
// of one DMA staging FIFO between NUM_REQ requesters. A grant is locked for
// one whole packet, and the granted requester's beats are muxed onto the
// FIFO write port. FIFO occupancy is tracked locally, so backpressure
// reacts without waiting for the FIFO's registered full flag.
//
// Ports:
//   clkin         - sole clock, rising edge
//   sync_reset    - synchronous active-high reset; also forces the
//                   combinational outputs low while it is asserted
//   req_valid     - per-requester beat valid
//   req_last      - per-requester end-of-packet marker, qualified by valid
//   req_data      - requester i occupies bits [i*BUF_DATAWIDTH +: BUF_DATAWIDTH]
//   req_ready     - per-requester ready; a beat moves when valid & ready
//   fifo_data     - FIFO write data (granted requester's beat)
//   fifo_wr_en    - FIFO write enable
//   fifo_rd_en    - copy of the FIFO consumer's read enable
//   fifo_level    - local occupancy count, 0..BUF_DEPTH
//   grant_valid   - a packet grant is held
//   grant_id      - index of the granted requester
//   err_overlen   - sticky: a packet was cut off at MAX_BEATS
//   err_underflow - sticky: a read arrived while the level was 0
module cpm5n_dma5_fifo_wr_arb #(
  parameter int NUM_REQ       = 4,
  parameter int BUF_DATAWIDTH = 256,
  parameter int BUF_DEPTH     = 512,
  parameter int BUF_PTR       = $clog2(BUF_DEPTH),
  parameter int MAX_BEATS     = 16,
  parameter int IDW           = $clog2(NUM_REQ)
) (
  input  logic                             clkin,
  input  logic                             sync_reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*BUF_DATAWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [BUF_DATAWIDTH-1:0]         fifo_data,
  output logic                             fifo_wr_en,
  input  logic                             fifo_rd_en,
  output logic [BUF_PTR:0]                 fifo_level,
  output logic                             grant_valid,
  output logic [IDW-1:0]                   grant_id,
  output logic                             err_overlen,
  output logic                             err_underflow
);

  // The beat counter only needs to reach MAX_BEATS-1; a one-beat limit
  // still gets a 1-bit counter so the vector is never zero-width.
  localparam int BCW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  localparam logic [BCW-1:0]   LAST_BEAT = BCW'(MAX_BEATS - 1);
  localparam logic [BUF_PTR:0] DEPTH_LVL = (BUF_PTR + 1)'(BUF_DEPTH);
  localparam logic [IDW-1:0]   LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]     NUM_WIDE  = (IDW + 1)'(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         rr_ptr_nxt;
  logic [IDW-1:0]         grant_id_nxt;
  logic [BCW-1:0]         beat_cnt;
  logic [BCW-1:0]         beat_cnt_nxt;
  logic [2*NUM_REQ-1:0]   valid_rot;
  logic [IDW:0]           arb_cand;
  logic [IDW-1:0]         arb_pick;
  logic                   arb_found;
  logic                   space_ok;
  logic                   pop_eff;
  logic                   set_overlen;

  // Round-robin search. Shifting a doubled copy of req_valid right by
  // rr_ptr puts the requester at rr_ptr into bit 0, so the first set bit
  // of the low half is the first valid requester scanning upward from
  // rr_ptr. The matching index is rebuilt as rr_ptr+k folded modulo
  // NUM_REQ. A plain mask would not work when NUM_REQ is not a power of 2.
  always_comb begin
    valid_rot = {req_valid, req_valid} >> rr_ptr;
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_found && valid_rot[k]) begin
        arb_found = 1'b1;
        arb_cand  = {1'b0, rr_ptr} + (IDW + 1)'(k);
        if (arb_cand >= NUM_WIDE) begin
          arb_cand = arb_cand - NUM_WIDE;
        end
        arb_pick = arb_cand[IDW-1:0];
      end
    end
  end

  // Write-port mux and handshake. Ready is computed from the current level
  // only, so a pop in the same cycle cannot open a write slot at full.
  // Everything here is held low while reset is asserted.
  always_comb begin
    space_ok   = (fifo_level < DEPTH_LVL);
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    if (!sync_reset) begin
      fifo_data = req_data[int'(grant_id)*BUF_DATAWIDTH +: BUF_DATAWIDTH];
      if (state == LOCK) begin
        req_ready[grant_id] = space_ok;
        fifo_wr_en          = req_valid[grant_id] & space_ok;
      end
    end
  end

  // A read only counts as a pop when there is something to pop.
  assign pop_eff = fifo_rd_en & (fifo_level != '0);

  // Next-state logic. A packet ends on its last beat, or is cut off at
  // MAX_BEATS. When it is cut off, the requester's remaining beats
  // re-arbitrate later as a fresh packet. The rotation pointer always moves
  // one past the requester just served.
  always_comb begin
    state_nxt    = state;
    grant_id_nxt = grant_id;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    set_overlen  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nxt    = LOCK;
          grant_id_nxt = arb_pick;
          beat_cnt_nxt = '0;
        end
      end
      LOCK: begin
        if (fifo_wr_en) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (req_last[grant_id] || (beat_cnt == LAST_BEAT)) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
            rr_ptr_nxt   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            set_overlen  = ~req_last[grant_id];
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, occupancy and sticky error registers. A write and a pop in the
  // same cycle cancel out. The error flags clear only on reset.
  always_ff @(posedge clkin) begin
    if (sync_reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      beat_cnt      <= '0;
      fifo_level    <= '0;
      err_overlen   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_id_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (fifo_wr_en && !pop_eff) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (!fifo_wr_en && pop_eff) begin
        fifo_level <= fifo_level - 1'b1;
      end
      if (set_overlen) begin
        err_overlen <= 1'b1;
      end
      if (fifo_rd_en && (fifo_level == '0)) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // The grant is held exactly while the state register is in LOCK.
  assign grant_valid = (state == LOCK);

endmodule
